test_ctrl_wb: RTL and testbench
===============================

# test_ctrl_wb

Wishbone slave peripheral on the core's LSU bus that turns riscv-tests and compliance runs into a synthesizable pass/fail/timeout verdict. Software writes the riscv-tests `tohost` encoding to a register and the block latches the verdict. A watchdog flags hung tests. The block holds the signature bounds for the bench's memory dump, and an optional console FIFO streams characters to the bench or a UART.

## Interface
- `ADDR_W`, 32, width of `wb_adr_i` (byte address); only bits [4:2] are decoded.
- `MAX_TICKS`, 100000, watchdog limit in cycles after reset release.
- `TIMEOUT_CODE`, 666, error code reported on timeout.
- `FIFO_DEPTH`, 4, console FIFO entries (power of two, ≥2).
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. One clock; reset is synchronous and active-high.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in ADDR_W: byte address.
- `wb_sel_i` in 4: byte selects. Ignored; every access is a full word.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: read data.
- `wb_ack_o` out 1: acknowledge.
- `wb_stall_o` out 1: pipelined-Wishbone stall.
- `done_o` out 1: verdict latched (pass, fail or timeout).
- `pass_o` out 1: test passed. Valid while `done_o` is high.
- `err_code_o` out 31: failure code. 0 on pass.
- `con_valid_o` out 1: console byte available.
- `con_data_o` out 8: console byte.
- `con_ready_i` in 1: consumer accepts the byte.

## Operation
- Register map (offset):
  - 0x00 TOHOST (W).
  - 0x04 STATUS (R): {29'b0, timeout, pass, done}.
  - 0x08 CYCLES (R): cycles since reset, saturating at 2^32-1.
  - 0x0C SIG_BEGIN (R/W).
  - 0x10 SIG_END (R/W).
  - 0x14 CONSOLE (W): byte = `wb_dat_i[7:0]`.
  - Other offsets: reads return 0, writes are dropped; both are acked.
- Reading TOHOST or CONSOLE returns 0.
- State machine: RUN → PASS | FAIL | TIMEOUT. The three terminal states are left only by reset.
- TOHOST write in RUN with `wb_dat_i[0]=1`:
  - value == 1 → PASS, `err_code_o`=0.
  - otherwise → FAIL, `err_code_o`=`wb_dat_i[31:1]`.
- TOHOST write with bit0=0 is ignored. Any TOHOST write outside RUN is ignored (first verdict wins).
- Watchdog: in RUN, when CYCLES reaches MAX_TICKS → TIMEOUT, `err_code_o`=TIMEOUT_CODE, `pass_o`=0.
- Same cycle as the watchdog limit: an accepted TOHOST write takes precedence over TIMEOUT.
- `done_o` = state≠RUN. `pass_o` = state==PASS. STATUS.timeout = state==TIMEOUT.
- CYCLES keeps counting in terminal states.
- Console: an accepted CONSOLE write pushes the byte into the FIFO. The output pops on `con_valid_o && con_ready_i`. A push and a pop in the same cycle on a full FIFO are both allowed.

## Timing
- A request is accepted when `wb_cyc_i && wb_stb_i && !wb_stall_o`.
- `wb_ack_o` pulses exactly one cycle after acceptance. `wb_dat_o` is registered and valid with the ack.
- Back-to-back requests give back-to-back acks.
- `wb_stall_o` is combinational: high only when a CONSOLE write is presented, the FIFO is full, and no pop happens this cycle. It is 0 otherwise.
- The state change and output update take effect the cycle after the accepting edge, coincident with the ack.
- Reset values:
  - `wb_ack_o`, `wb_dat_o`, `done_o`, `pass_o`, `err_code_o`, `con_valid_o` and `con_data_o` are 0.
  - CYCLES, SIG_BEGIN, SIG_END, FIFO pointers and count are 0; state is RUN.
- Reset asserted mid-transaction drops the pending ack and flushes the FIFO. The master must restart the cycle.
- `cyc_i` deasserted while an ack is pending: the ack is still driven and the master ignores it. No state rollback.

## Configuration
- `TEST_CTRL_CONSOLE_EN` defined: the console FIFO and handshake are compiled in.
- Not defined:
  - CONSOLE writes are acked and discarded; `wb_stall_o` is constant 0.
  - `con_valid_o` and `con_data_o` are tied 0; `con_ready_i` is unused.
  - No FIFO storage is instantiated.

## Structure
- `test_ctrl_pkg` holds:
  - register offset localparams (TOHOST_OFF … CONSOLE_OFF);
  - the `test_state_t` enum {RUN, PASS, FAIL, TIMEOUT};
  - a STATUS bit-index constant for each field.
- Sub-module `sync_fifo` (DATA_W, DEPTH) provides the console buffer, instantiated under the macro.

## Test plan
- Write TOHOST=0x1 at cycle 50 → next cycle `done_o`=1, `pass_o`=1, `err_code_o`=0; STATUS reads 0x3.
- Write TOHOST=0x7, then TOHOST=0x1 → FAIL latched, `err_code_o`=3; the second write is ignored but still acked.
- No TOHOST write, MAX_TICKS=200 → at 200 cycles after reset release, `done_o`=1, `err_code_o`=666, STATUS=0x5.
- TOHOST=0x1 accepted in the same cycle the limit is hit → PASS, not TIMEOUT.
- With the macro defined, `con_ready_i`=0, write 'A','B','C','D','E':
  - the fifth write stalls;
  - raise `con_ready_i` → bytes come out 0x41..0x45 in order and the stall releases.
- Write SIG_BEGIN=0x2000 and SIG_END=0x2100, read both back → 0x2000 and 0x2100. Assert `rst_i` mid-read → no ack; every output returns to 0.

Source files
------------

// File: rtl/test_ctrl_pkg.sv
// Shared register map, verdict state and STATUS layout for test_ctrl_wb.
// Used by the top and by the bench-facing sub-blocks.
package test_ctrl_pkg;

  localparam logic [4:0] TOHOST_OFF    = 5'h00;
  localparam logic [4:0] STATUS_OFF    = 5'h04;
  localparam logic [4:0] CYCLES_OFF    = 5'h08;
  localparam logic [4:0] SIG_BEGIN_OFF = 5'h0C;
  localparam logic [4:0] SIG_END_OFF   = 5'h10;
  localparam logic [4:0] CONSOLE_OFF   = 5'h14;

  localparam int ST_DONE_BIT    = 0;
  localparam int ST_PASS_BIT    = 1;
  localparam int ST_TIMEOUT_BIT = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } test_state_t;

endpackage

// File: rtl/test_ctrl_wb_sync_fifo.sv
// Small synchronous FIFO used as the console buffer.
// A push on a full FIFO is allowed when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  // Gate the head so the output reads 0 while empty.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/test_ctrl_wb.sv
// Wishbone test controller: tohost verdict, watchdog, signature bounds.
// Console FIFO compiled in only when TEST_CTRL_CONSOLE_EN is defined.
module test_ctrl_wb
  import test_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int MAX_TICKS    = 100000,
  parameter int TIMEOUT_CODE = 666,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [30:0]       err_code_o,
  output logic              con_valid_o,
  output logic [7:0]        con_data_o,
  input  logic              con_ready_i
);

  localparam logic [31:0] WD_LIM  = 32'(MAX_TICKS - 1);
  localparam logic [30:0] TO_CODE = 31'(TIMEOUT_CODE);

  test_state_t state_q, state_d;
  logic [30:0] err_q, err_d;
  logic [31:0] cycles_q;
  logic [31:0] sigb_q, sige_q;
  logic [31:0] dat_q, rdata;
  logic        ack_q;
  logic [4:0]  off;
  logic        req, accept, wr, rd;
  logic        sel_tohost, sel_status, sel_cycles;
  logic        sel_sigb, sel_sige, sel_console;
  logic        tohost_wr;

  assign off         = {wb_adr_i[4:2], 2'b00};
  assign sel_tohost  = (off == TOHOST_OFF);
  assign sel_status  = (off == STATUS_OFF);
  assign sel_cycles  = (off == CYCLES_OFF);
  assign sel_sigb    = (off == SIG_BEGIN_OFF);
  assign sel_sige    = (off == SIG_END_OFF);
  assign sel_console = (off == CONSOLE_OFF);

  assign req    = wb_cyc_i && wb_stb_i;
  assign accept = req && !wb_stall_o;
  assign wr     = accept && wb_we_i;
  assign rd     = accept && !wb_we_i;

  assign tohost_wr = wr && sel_tohost && wb_dat_i[0];

`ifdef TEST_CTRL_CONSOLE_EN
  logic fifo_full, fifo_empty;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_con_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr && sel_console),
    .data_i  (wb_dat_i[7:0]),
    .pop_i   (con_ready_i),
    .data_o  (con_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign con_valid_o = !fifo_empty;
  // A pop this cycle frees a slot, so a full FIFO need not stall.
  assign wb_stall_o  = req && wb_we_i && sel_console && fifo_full &&
                       !(con_valid_o && con_ready_i);

  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_adr_i[ADDR_W-1:5], wb_adr_i[1:0]};
`else
  assign con_valid_o = 1'b0;
  assign con_data_o  = 8'h00;
  assign wb_stall_o  = 1'b0;

  logic unused_in;
  assign unused_in = ^{wb_sel_i, wb_adr_i[ADDR_W-1:5], wb_adr_i[1:0],
                       con_ready_i};
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (state_q == RUN) begin
      // A software verdict beats the watchdog on the same edge.
      if (tohost_wr) begin
        if (wb_dat_i == 32'd1) begin
          state_d = PASS;
          err_d   = '0;
        end else begin
          state_d = FAIL;
          err_d   = wb_dat_i[31:1];
        end
      end else if (cycles_q >= WD_LIM) begin
        state_d = TIMEOUT;
        err_d   = TO_CODE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_status: begin
        rdata[ST_DONE_BIT]    = (state_q != RUN);
        rdata[ST_PASS_BIT]    = (state_q == PASS);
        rdata[ST_TIMEOUT_BIT] = (state_q == TIMEOUT);
      end
      sel_cycles: rdata = cycles_q;
      sel_sigb:   rdata = sigb_q;
      sel_sige:   rdata = sige_q;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q <= '0;
      sigb_q   <= '0;
      sige_q   <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
      if (wr && sel_sigb) sigb_q <= wb_dat_i;
      if (wr && sel_sige) sige_q <= wb_dat_i;
      ack_q <= accept;
      dat_q <= rd ? rdata : '0;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign done_o     = (state_q != RUN);
  assign pass_o     = (state_q == PASS);
  assign err_code_o = err_q;

endmodule

// File: tb/tb_test_ctrl_wb.sv
// Directed self-checking bench for test_ctrl_wb (MAX_TICKS=200).
// Console checks follow TEST_CTRL_CONSOLE_EN.
module tb_test_ctrl_wb;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_stall_o;
  logic        done_o;
  logic        pass_o;
  logic [30:0] err_code_o;
  logic        con_valid_o;
  logic [7:0]  con_data_o;
  logic        con_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  test_ctrl_wb #(
    .ADDR_W       (32),
    .MAX_TICKS    (200),
    .TIMEOUT_CODE (666),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .wb_stall_o  (wb_stall_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .err_code_o  (err_code_o),
    .con_valid_o (con_valid_o),
    .con_data_o  (con_data_o),
    .con_ready_i (con_ready_i)
  );

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // Ends on a negedge with reset released; the next posedge is cycle 1.
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [31:0] adr,
                     input logic [31:0] dat,
                     output logic [31:0] rdat, output logic ack);
    int n;
    n = 0;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    #1;
    while (wb_stall_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (wb_stall_o) begin
      checks++;
      errors++;
      $display("FAIL bus_stall_bound adr=%h still stalled", adr);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      rdat = '0;
      ack  = 1'b0;
    end else begin
      @(posedge clk);
      @(negedge clk);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_we_i  = 1'b0;
      rdat = wb_dat_o;
      ack  = wb_ack_o;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wb_ack_o, wb_dat_o, done_o, pass_o, err_code_o,
         con_valid_o, con_data_o, wb_stall_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b dat=%h done=%b pass=%b err=%0d cv=%b cd=%h stall=%b required all 0",
               wb_ack_o, wb_dat_o, done_o, pass_o, err_code_o,
               con_valid_o, con_data_o, wb_stall_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_pass();
    logic [31:0] rd;
    logic ack;
    do_reset();
    repeat (49) @(posedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL pass_pre_done got %b required 0", done_o);
    end
    bus(1'b1, 32'h0, 32'h1, rd, ack);
    checks++;
    if ({ack, done_o, pass_o, err_code_o} !== {1'b1, 1'b1, 1'b1, 31'd0}) begin
      errors++;
      $display("FAIL pass_verdict ack=%b done=%b pass=%b err=%0d required 1 1 1 0",
               ack, done_o, pass_o, err_code_o);
    end
    bus(1'b0, 32'h4, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h3 || ack !== 1'b1) begin
      errors++;
      $display("FAIL pass_status got %h ack=%b required 3 ack=1", rd, ack);
    end
  endtask

  task automatic test_fail();
    logic [31:0] rd;
    logic ack;
    do_reset();
    bus(1'b1, 32'h0, 32'h7, rd, ack);
    checks++;
    if ({ack, done_o, pass_o, err_code_o} !== {1'b1, 1'b1, 1'b0, 31'd3}) begin
      errors++;
      $display("FAIL fail_verdict ack=%b done=%b pass=%b err=%0d required 1 1 0 3",
               ack, done_o, pass_o, err_code_o);
    end
    bus(1'b1, 32'h0, 32'h1, rd, ack);
    checks++;
    if ({ack, pass_o, err_code_o} !== {1'b1, 1'b0, 31'd3}) begin
      errors++;
      $display("FAIL fail_first_wins ack=%b pass=%b err=%0d required 1 0 3",
               ack, pass_o, err_code_o);
    end
    bus(1'b0, 32'h4, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h1) begin
      errors++;
      $display("FAIL fail_status got %h required 1", rd);
    end
  endtask

  task automatic test_ignore_even();
    logic [31:0] rd;
    logic ack;
    do_reset();
    bus(1'b1, 32'h0, 32'h6, rd, ack);
    checks++;
    if ({ack, done_o} !== 2'b10) begin
      errors++;
      $display("FAIL even_tohost ack=%b done=%b required 1 0", ack, done_o);
    end
    bus(1'b0, 32'h0, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL tohost_read got %h required 0", rd);
    end
    bus(1'b0, 32'h18, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      errors++;
      $display("FAIL unmapped_read got %h ack=%b required 0 ack=1", rd, ack);
    end
  endtask

  task automatic test_cycles();
    logic [31:0] rd;
    logic ack;
    do_reset();
    repeat (9) @(posedge clk);
    bus(1'b0, 32'h8, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'd9) begin
      errors++;
      $display("FAIL cycles_read got %0d required 9", rd);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    logic ack;
    do_reset();
    repeat (199) @(posedge clk);
    @(negedge clk);
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early done=%b required 0 at 199", done_o);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({done_o, pass_o, err_code_o} !== {1'b1, 1'b0, 31'd666}) begin
      errors++;
      $display("FAIL timeout_verdict done=%b pass=%b err=%0d required 1 0 666",
               done_o, pass_o, err_code_o);
    end
    bus(1'b0, 32'h4, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h5) begin
      errors++;
      $display("FAIL timeout_status got %h required 5", rd);
    end
    bus(1'b1, 32'h0, 32'h1, rd, ack);
    checks++;
    if ({ack, pass_o, err_code_o} !== {1'b1, 1'b0, 31'd666}) begin
      errors++;
      $display("FAIL timeout_sticky ack=%b pass=%b err=%0d required 1 0 666",
               ack, pass_o, err_code_o);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] rd;
    logic ack;
    do_reset();
    repeat (199) @(posedge clk);
    bus(1'b1, 32'h0, 32'h1, rd, ack);
    checks++;
    if ({ack, done_o, pass_o, err_code_o} !== {1'b1, 1'b1, 1'b1, 31'd0}) begin
      errors++;
      $display("FAIL same_cycle_pass ack=%b done=%b pass=%b err=%0d required 1 1 1 0",
               ack, done_o, pass_o, err_code_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] adrs [3];
    logic [31:0] exps [3];
    logic [31:0] rd;
    logic ack;
    do_reset();
    bus(1'b1, 32'hC, 32'h2000, rd, ack);
    bus(1'b1, 32'h10, 32'h2100, rd, ack);
    bus(1'b1, 32'h1C, 32'hDEAD, rd, ack);
    adrs[0] = 32'hC;  exps[0] = 32'h2000;
    adrs[1] = 32'h10; exps[1] = 32'h2100;
    adrs[2] = 32'h1C; exps[2] = 32'h0;
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== exps[i-1]) begin
          errors++;
          $display("FAIL b2b_read%0d ack=%b dat=%h required ack=1 dat=%h",
                   i - 1, wb_ack_o, wb_dat_o, exps[i-1]);
        end
      end
      if (i < 3) begin
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b0;
        wb_adr_i = adrs[i];
      end else begin
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_end got %b required 0", wb_ack_o);
    end
  endtask

  task automatic test_mid_reset();
    logic [31:0] rd;
    logic ack;
    do_reset();
    bus(1'b1, 32'hC, 32'h2000, rd, ack);
    bus(1'b1, 32'h0, 32'h1, rd, ack);
`ifdef TEST_CTRL_CONSOLE_EN
    con_ready_i = 1'b0;
    bus(1'b1, 32'h14, 32'h5A, rd, ack);
`endif
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = 32'hC;
    rst_i    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    checks++;
    if ({wb_ack_o, wb_dat_o, done_o, pass_o, err_code_o,
         con_valid_o, con_data_o} !== '0) begin
      errors++;
      $display("FAIL mid_reset ack=%b dat=%h done=%b pass=%b err=%0d cv=%b cd=%h required all 0",
               wb_ack_o, wb_dat_o, done_o, pass_o, err_code_o,
               con_valid_o, con_data_o);
    end
    rst_i = 1'b0;
    bus(1'b0, 32'hC, 32'h0, rd, ack);
    checks++;
    if (rd !== 32'h0 || ack !== 1'b1) begin
      errors++;
      $display("FAIL sig_after_reset got %h ack=%b required 0 ack=1", rd, ack);
    end
  endtask

`ifdef TEST_CTRL_CONSOLE_EN
  task automatic test_console();
    logic [31:0] rd;
    logic ack;
    logic [7:0] got [5];
    int n;
    int k;
    do_reset();
    con_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, 32'h14, 32'(8'h41 + i), rd, ack);
    end
    checks++;
    if (con_valid_o !== 1'b1 || con_data_o !== 8'h41) begin
      errors++;
      $display("FAIL con_head valid=%b data=%h required 1 41",
               con_valid_o, con_data_o);
    end
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b1;
    wb_adr_i = 32'h14;
    wb_dat_i = 32'h45;
    #1;
    checks++;
    if (wb_stall_o !== 1'b1) begin
      errors++;
      $display("FAIL con_stall_full got %b required 1", wb_stall_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (wb_stall_o !== 1'b1 || wb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL con_stall_hold stall=%b ack=%b required 1 0",
               wb_stall_o, wb_ack_o);
    end
    con_ready_i = 1'b1;
    #1;
    checks++;
    if (wb_stall_o !== 1'b0) begin
      errors++;
      $display("FAIL con_stall_release got %b required 0", wb_stall_o);
    end
    n = 0;
    if (con_valid_o) begin
      got[0] = con_data_o;
      n = 1;
    end
    @(posedge clk);
    @(negedge clk);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    checks++;
    if (wb_ack_o !== 1'b1) begin
      errors++;
      $display("FAIL con_fifth_ack got %b required 1", wb_ack_o);
    end
    k = 0;
    while (n < 5 && k < 20) begin
      if (con_valid_o) begin
        got[n] = con_data_o;
        n++;
      end
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= n || got[i] !== 8'(8'h41 + i)) begin
        errors++;
        $display("FAIL con_byte%0d got %h required %h (received %0d)",
                 i, (i < n) ? got[i] : 8'h00, 8'(8'h41 + i), n);
      end
    end
    checks++;
    if (con_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL con_drained valid=%b required 0", con_valid_o);
    end
    con_ready_i = 1'b0;
  endtask
`else
  task automatic test_console();
    logic [31:0] rd;
    logic ack;
    do_reset();
    con_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus(1'b1, 32'h14, 32'(8'h41 + i), rd, ack);
      checks++;
      if (ack !== 1'b1 || con_valid_o !== 1'b0 || con_data_o !== 8'h00) begin
        errors++;
        $display("FAIL con_off%0d ack=%b valid=%b data=%h required 1 0 00",
                 i, ack, con_valid_o, con_data_o);
      end
    end
    con_ready_i = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_ignore_even();
    test_cycles();
    test_timeout();
    test_same_cycle();
    test_back_to_back();
    test_console();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
